// File: rtl/k12_nonce_dispatcher_if.sv
// Job offer channel into the K12 nonce dispatcher: valid/ready handshake plus the job descriptor.
interface k12_nonce_dispatcher_if #(
  parameter int unsigned COUNT_W = 32
);
  logic               job_valid;
  logic               job_ready;
  logic [575:0]       job_blob;
  logic [63:0]        job_target;
  logic [63:0]        job_start_nonce;
  logic [COUNT_W-1:0] job_count;

  modport master (
    output job_valid, job_blob, job_target, job_start_nonce, job_count,
    input  job_ready
  );

  modport slave (
    input  job_valid, job_blob, job_target, job_start_nonce, job_count,
    output job_ready
  );
endinterface

// File: rtl/k12_nonce_dispatcher.sv
// Upstream scheduler for K12_PoW: one hash in flight, one load pulse per nonce every HASH_LAT+1 cycles,
// and any store seen during a nonce's window is tagged with that nonce.
module k12_nonce_dispatcher #(
  parameter int unsigned HASH_LAT     = 14,
  parameter int unsigned COUNT_W      = 32,
  parameter bit          STOP_ON_FIND = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  k12_nonce_dispatcher_if.slave job_if,
  input  logic                  abort_i,
  output logic                  pow_load_o,
  output logic [63:0]           pow_nonce_o,
  output logic [575:0]          pow_blob_o,
  output logic [63:0]           pow_target_o,
  input  logic                  pow_store_i,
  input  logic [255:0]          pow_hash_i,
  output logic                  found_valid_o,
  output logic [63:0]           found_nonce_o,
  output logic [255:0]          found_hash_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [COUNT_W-1:0]    hashes_done_o
);

  localparam int unsigned TIMER_W = $clog2(HASH_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [COUNT_W-1:0] remaining_q;
  logic [COUNT_W-1:0] hashes_q;
  logic [63:0]        nonce_q;
  logic [575:0]       blob_q;
  logic [63:0]        target_q;
  logic               hit_q;
  logic               pow_load_q;
  logic               found_valid_q;
  logic [63:0]        found_nonce_q;
  logic [255:0]       found_hash_q;
  logic               busy_q;
  logic               ready_q;
  logic               done_q;

  logic [63:0]        nonce_d;
  logic [COUNT_W-1:0] remaining_d;
  logic [COUNT_W-1:0] hashes_d;
  logic               store_hit_d;
  logic               end_job_d;

  always_comb begin
    nonce_d     = nonce_q + 64'd1;
    remaining_d = remaining_q - COUNT_W'(1);
    hashes_d    = (hashes_q == {COUNT_W{1'b1}}) ? hashes_q : hashes_q + COUNT_W'(1);
    store_hit_d = pow_store_i && !hit_q;
    // A hit in the closing cycle of the window still counts towards stop-on-find.
    end_job_d   = (remaining_d == {COUNT_W{1'b0}}) || (STOP_ON_FIND && (hit_q || pow_store_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= {TIMER_W{1'b0}};
      remaining_q   <= {COUNT_W{1'b0}};
      hashes_q      <= {COUNT_W{1'b0}};
      nonce_q       <= 64'd0;
      blob_q        <= 576'd0;
      target_q      <= 64'd0;
      hit_q         <= 1'b0;
      pow_load_q    <= 1'b0;
      found_valid_q <= 1'b0;
      found_nonce_q <= 64'd0;
      found_hash_q  <= 256'd0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      pow_load_q    <= 1'b0;
      found_valid_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (job_if.job_valid && ready_q) begin
            blob_q      <= job_if.job_blob;
            target_q    <= job_if.job_target;
            nonce_q     <= job_if.job_start_nonce;
            remaining_q <= job_if.job_count;
            hashes_q    <= {COUNT_W{1'b0}};
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            if (job_if.job_count == {COUNT_W{1'b0}}) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_LOAD;
              pow_load_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            timer_q <= TIMER_W'(HASH_LAT - 1);
            hit_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          // Abort drops any store seen this cycle, so no found pulse leaks out.
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
            if (store_hit_d) begin
              found_valid_q <= 1'b1;
              found_nonce_q <= nonce_q;
              found_hash_q  <= pow_hash_i;
              hit_q         <= 1'b1;
            end
            if (timer_q == {TIMER_W{1'b0}}) begin
              nonce_q     <= nonce_d;
              remaining_q <= remaining_d;
              hashes_q    <= hashes_d;
              if (end_job_d) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_LOAD;
                pow_load_q <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign job_if.job_ready = ready_q;
  assign pow_load_o       = pow_load_q;
  assign pow_nonce_o      = nonce_q;
  assign pow_blob_o       = blob_q;
  assign pow_target_o     = target_q;
  assign found_valid_o    = found_valid_q;
  assign found_nonce_o    = found_nonce_q;
  assign found_hash_o     = found_hash_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign hashes_done_o    = hashes_q;

endmodule

// File: tb/tb_k12_nonce_dispatcher.sv
// Bench for k12_nonce_dispatcher: two instances (sweep-all and stop-on-find) share one stimulus stream;
// observed load/found/done events are compared against a window-level reference model.
module tb_k12_nonce_dispatcher;

  localparam int HL = 14;
  localparam int CW = 32;

  typedef struct {
    int           d;
    int           kind;
    int           cyc;
    logic [63:0]  nonce;
    logic [255:0] hash;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic [575:0]  job_blob;
  logic [63:0]   job_target;
  logic [63:0]   job_start;
  logic [CW-1:0] job_count;
  logic          abort;
  logic          pow_store;
  logic [255:0]  pow_hash;

  logic          pl_a, fv_a, busy_a, done_a, pl_b, fv_b, busy_b, done_b;
  logic [63:0]   pn_a, pt_a, fn_a, pn_b, pt_b, fn_b;
  logic [575:0]  pb_a, pb_b;
  logic [255:0]  fh_a, fh_b;
  logic [CW-1:0] hd_a, hd_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0;
  ev_t ev_q[$];
  ev_t exp_q[$];
  int exp_hd;
  int st_off_q[$];
  logic [255:0] st_hash_q[$];

  k12_nonce_dispatcher_if #(.COUNT_W(CW)) ifa ();
  k12_nonce_dispatcher_if #(.COUNT_W(CW)) ifb ();

  assign ifa.job_valid = job_valid;        assign ifb.job_valid = job_valid;
  assign ifa.job_blob = job_blob;          assign ifb.job_blob = job_blob;
  assign ifa.job_target = job_target;      assign ifb.job_target = job_target;
  assign ifa.job_start_nonce = job_start;  assign ifb.job_start_nonce = job_start;
  assign ifa.job_count = job_count;        assign ifb.job_count = job_count;

  k12_nonce_dispatcher #(.HASH_LAT(HL), .COUNT_W(CW), .STOP_ON_FIND(1'b0)) dut_a (
    .clk(clk), .rst(rst), .job_if(ifa), .abort_i(abort),
    .pow_load_o(pl_a), .pow_nonce_o(pn_a), .pow_blob_o(pb_a), .pow_target_o(pt_a),
    .pow_store_i(pow_store), .pow_hash_i(pow_hash),
    .found_valid_o(fv_a), .found_nonce_o(fn_a), .found_hash_o(fh_a),
    .busy_o(busy_a), .done_o(done_a), .hashes_done_o(hd_a)
  );

  k12_nonce_dispatcher #(.HASH_LAT(HL), .COUNT_W(CW), .STOP_ON_FIND(1'b1)) dut_b (
    .clk(clk), .rst(rst), .job_if(ifb), .abort_i(abort),
    .pow_load_o(pl_b), .pow_nonce_o(pn_b), .pow_blob_o(pb_b), .pow_target_o(pt_b),
    .pow_store_i(pow_store), .pow_hash_i(pow_hash),
    .found_valid_o(fv_b), .found_nonce_o(fn_b), .found_hash_o(fh_b),
    .busy_o(busy_b), .done_o(done_b), .hashes_done_o(hd_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int d, input int kind, input int c, input logic [63:0] n,
                                input logic [255:0] h);
    ev_t e;
    e.d = d; e.kind = kind; e.cyc = c; e.nonce = n; e.hash = h;
    return e;
  endfunction

  // Event recorder, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (pl_a === 1'b1) ev_q.push_back(mk_ev(0, 0, cyc, pn_a, 256'd0));
    if (fv_a === 1'b1) ev_q.push_back(mk_ev(0, 1, cyc, fn_a, fh_a));
    if (done_a === 1'b1) ev_q.push_back(mk_ev(0, 2, cyc, 64'd0, 256'd0));
    if (pl_b === 1'b1) ev_q.push_back(mk_ev(1, 0, cyc, pn_b, 256'd0));
    if (fv_b === 1'b1) ev_q.push_back(mk_ev(1, 1, cyc, fn_b, fh_b));
    if (done_b === 1'b1) ev_q.push_back(mk_ev(1, 2, cyc, 64'd0, 256'd0));
  end

  task automatic rnd_job;
    for (int i = 0; i < 18; i++) job_blob[i*32 +: 32] = $urandom();
    job_target = {$urandom(), $urandom()};
  endtask

  // Offers the job in cycle c0 and then plays st_off_q / abort_off (offsets from c0) for run_len cycles.
  task automatic run_job(input int abort_off, input int run_len);
    @(posedge clk); #1;
    ev_q.delete();
    c0 = cyc;
    for (int i = 0; i < run_len; i++) begin
      job_valid = (i == 0);
      abort = (i == abort_off);
      pow_store = 1'b0;
      pow_hash = {8{$urandom()}};
      foreach (st_off_q[j]) begin
        if (!pow_store && st_off_q[j] == i) begin
          pow_store = 1'b1;
          pow_hash = st_hash_q[j];
        end
      end
      @(posedge clk); #1;
    end
    job_valid = 1'b0; abort = 1'b0; pow_store = 1'b0;
  endtask

  // Reference: loads every HL+1 cycles from first load a; first store inside a nonce's HL-cycle window
  // produces a found one cycle later; abort in cycle x cancels everything after x.
  task automatic build_model(input int d, input int a, input logic [63:0] s, input int n, input int x);
    ev_t ld[$];
    ev_t fd[$];
    int nk, dcyc, lc, xe;
    bit hit, stopped;
    exp_q.delete();
    nk = 0; exp_hd = 0; stopped = 1'b0;
    xe = (x < a) ? 32'h7fff_ffff : x;
    for (int k = 0; k < n && !stopped; k++) begin
      lc = a + k * (HL + 1);
      hit = 1'b0;
      ld.push_back(mk_ev(d, 0, lc, s + 64'(k), 256'd0));
      for (int c = lc + 1; c <= lc + HL; c++) begin
        foreach (st_off_q[j]) begin
          if (!hit && c0 + st_off_q[j] == c) begin
            hit = 1'b1;
            fd.push_back(mk_ev(d, 1, c + 1, s + 64'(k), st_hash_q[j]));
          end
        end
      end
      nk = k + 1;
      if (lc + HL < xe) exp_hd++;
      if (d == 1 && hit) stopped = 1'b1;
    end
    dcyc = a + nk * (HL + 1);
    for (int c = a; c <= dcyc && c <= xe; c++) begin
      if (ld.size() > 0 && ld[0].cyc == c) exp_q.push_back(ld.pop_front());
      if (fd.size() > 0 && fd[0].cyc == c) exp_q.push_back(fd.pop_front());
      if (c == dcyc) exp_q.push_back(mk_ev(d, 2, c, 64'd0, 256'd0));
    end
  endtask

  task automatic test_reset;
    logic [4:0] flags;
    logic       zero;
    for (int d = 0; d < 2; d++) begin
      flags = (d == 0) ? {ifa.job_ready, busy_a, pl_a, fv_a, done_a} : {ifb.job_ready, busy_b, pl_b, fv_b, done_b};
      zero = (d == 0) ? (hd_a == 32'd0 && pn_a == 64'd0 && pb_a == 576'd0 && pt_a == 64'd0 &&
                         fn_a == 64'd0 && fh_a == 256'd0)
                      : (hd_b == 32'd0 && pn_b == 64'd0 && pb_b == 576'd0 && pt_b == 64'd0 &&
                         fn_b == 64'd0 && fh_b == 256'd0);
      total++;
      if (flags !== 5'b10000) begin
        bad++; $display("FAIL reset_flags dut=%0d got=%b want=10000", d, flags);
      end
      total++;
      if (zero !== 1'b1) begin
        bad++; $display("FAIL reset_values dut=%0d got_nonzero=%b want=0", d, ~zero);
      end
    end
  endtask

  task automatic test_reset_midjob;
    st_off_q.delete(); st_hash_q.delete();
    rnd_job(); job_start = 64'h1234; job_count = 32'd5;
    run_job(-1, 20);
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL midjob_busy got=%b want=1", busy_a); end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    st_off_q.delete(); st_hash_q.delete();
    rnd_job(); job_start = 64'h10; job_count = 32'd3;
    run_job(-1, 3 * (HL + 1) + 4);
    for (int d = 0; d < 2; d++) begin
      int nl, nd, nf;
      nl = 0; nd = 0; nf = 0;
      foreach (ev_q[i]) begin
        if (ev_q[i].d == d) begin
          if (ev_q[i].kind == 0) begin
            total++;
            if (ev_q[i].nonce !== 64'h10 + 64'(nl) || ev_q[i].cyc !== c0 + 1 + nl * 15) begin
              bad++; $display("FAIL sweep_load dut=%0d got=%h@%0d want=%h@%0d", d, ev_q[i].nonce,
                              ev_q[i].cyc - c0, 64'h10 + 64'(nl), 1 + nl * 15);
            end
            nl++;
          end else if (ev_q[i].kind == 2) begin
            total++;
            if (ev_q[i].cyc !== c0 + 46) begin
              bad++; $display("FAIL sweep_done_cyc dut=%0d got=%0d want=46", d, ev_q[i].cyc - c0);
            end
            nd++;
          end else nf++;
        end
      end
      total++;
      if (nl !== 3 || nd !== 1 || nf !== 0) begin
        bad++; $display("FAIL sweep_counts dut=%0d got=%0d/%0d/%0d want=3/1/0", d, nl, nd, nf);
      end
      total++;
      if (((d == 0) ? hd_a : hd_b) !== 32'd3) begin
        bad++; $display("FAIL sweep_hashes dut=%0d got=%0d want=3", d, (d == 0) ? hd_a : hd_b);
      end
    end
    total++;
    if (pb_a !== job_blob || pt_b !== job_target) begin
      bad++; $display("FAIL sweep_latch got=%h want=%h", pt_b, job_target);
    end
  endtask

  task automatic test_hit;
    st_off_q = '{13, 14};
    st_hash_q = '{{32{8'hAB}}, {32{8'hCD}}};
    rnd_job(); job_start = {$urandom(), $urandom()}; job_count = 32'd2;
    run_job(-1, 2 * (HL + 1) + 5);
    for (int d = 0; d < 2; d++) begin
      int nl, nf;
      nl = 0; nf = 0;
      foreach (ev_q[i]) begin
        if (ev_q[i].d == d && ev_q[i].kind == 0) nl++;
        if (ev_q[i].d == d && ev_q[i].kind == 1) begin
          nf++;
          total++;
          if (ev_q[i].nonce !== job_start || ev_q[i].hash !== {32{8'hAB}} || ev_q[i].cyc !== c0 + 14) begin
            bad++; $display("FAIL hit_found dut=%0d got=%h/%h@%0d want=%h/ab..@14", d, ev_q[i].nonce,
                            ev_q[i].hash, ev_q[i].cyc - c0, job_start);
          end
        end
      end
      total++;
      if (nf !== 1 || nl !== ((d == 0) ? 2 : 1)) begin
        bad++; $display("FAIL hit_counts dut=%0d got=%0d/%0d want=1/%0d", d, nf, nl, (d == 0) ? 2 : 1);
      end
      total++;
      if (((d == 0) ? hd_a : hd_b) !== ((d == 0) ? 32'd2 : 32'd1)) begin
        bad++; $display("FAIL hit_hashes dut=%0d got=%0d", d, (d == 0) ? hd_a : hd_b);
      end
    end
  endtask

  task automatic test_wrap;
    logic [63:0] want;
    int nl;
    st_off_q.delete(); st_hash_q.delete();
    rnd_job(); job_start = 64'hFFFF_FFFF_FFFF_FFFF; job_count = 32'd2;
    run_job(-1, 2 * (HL + 1) + 4);
    nl = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].d == 0 && ev_q[i].kind == 0) begin
        want = (nl == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
        total++;
        if (ev_q[i].nonce !== want) begin
          bad++; $display("FAIL wrap_nonce idx=%0d got=%h want=%h", nl, ev_q[i].nonce, want);
        end
        nl++;
      end
    end
    total++;
    if (nl !== 2) begin bad++; $display("FAIL wrap_loads got=%0d want=2", nl); end
  endtask

  task automatic test_zero;
    int nl, nd;
    st_off_q = '{1, 2};
    st_hash_q = '{{8{32'h5a5a_5a5a}}, {8{32'h1}}};
    rnd_job(); job_start = 64'h77; job_count = 32'd0;
    run_job(-1, 6);
    nl = 0; nd = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].kind == 0 || ev_q[i].kind == 1) nl++;
      if (ev_q[i].kind == 2) begin
        nd++;
        total++;
        if (ev_q[i].cyc !== c0 + 1) begin
          bad++; $display("FAIL zero_done_cyc dut=%0d got=%0d want=1", ev_q[i].d, ev_q[i].cyc - c0);
        end
      end
    end
    total++;
    if (nl !== 0 || nd !== 2) begin bad++; $display("FAIL zero_events got=%0d/%0d want=0/2", nl, nd); end
    total++;
    if (hd_a !== 32'd0 || hd_b !== 32'd0) begin
      bad++; $display("FAIL zero_hashes got=%0d/%0d want=0", hd_a, hd_b);
    end
  endtask

  task automatic test_abort;
    int nl, nx;
    st_off_q = '{22};
    st_hash_q = '{{8{32'hdead_beef}}};
    rnd_job(); job_start = 64'h400; job_count = 32'd3;
    run_job(22, 23);
    total++;
    if ({busy_a, ifa.job_ready, busy_b, ifb.job_ready} !== 4'b0101) begin
      bad++; $display("FAIL abort_idle got=%b want=0101", {busy_a, ifa.job_ready, busy_b, ifb.job_ready});
    end
    repeat (20) @(posedge clk);
    #1;
    nl = 0; nx = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].kind == 0) nl++;
      else nx++;
    end
    total++;
    if (nl !== 4 || nx !== 0) begin bad++; $display("FAIL abort_events got=%0d/%0d want=4/0", nl, nx); end
    total++;
    if (hd_a !== 32'd1 || hd_b !== 32'd1) begin
      bad++; $display("FAIL abort_hashes got=%0d/%0d want=1", hd_a, hd_b);
    end
  endtask

  task automatic test_random;
    ev_t act[$];
    int n, ns, abort_off, span;
    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(0, 4);
      span = n * (HL + 1) + 3;
      rnd_job();
      job_start = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3))
                                              : {$urandom(), $urandom()};
      job_count = CW'(n);
      st_off_q.delete(); st_hash_q.delete();
      ns = $urandom_range(0, 4);
      for (int j = 0; j < ns; j++) begin
        st_off_q.push_back($urandom_range(1, span));
        st_hash_q.push_back({8{$urandom()}});
      end
      case ($urandom_range(0, 3))
        0: abort_off = 0;
        1: abort_off = $urandom_range(1, span);
        default: abort_off = -1;
      endcase
      run_job(abort_off, span + 3);
      for (int d = 0; d < 2; d++) begin
        build_model(d, c0 + 1, job_start, n, (abort_off < 0) ? -1 : c0 + abort_off);
        act.delete();
        foreach (ev_q[i]) if (ev_q[i].d == d) act.push_back(ev_q[i]);
        total++;
        if (act.size() !== exp_q.size()) begin
          bad++; $display("FAIL rand_evcount it=%0d dut=%0d got=%0d want=%0d", it, d, act.size(), exp_q.size());
        end else begin
          foreach (exp_q[i]) begin
            total++;
            if (act[i].kind !== exp_q[i].kind || act[i].cyc !== exp_q[i].cyc ||
                act[i].nonce !== exp_q[i].nonce || act[i].hash !== exp_q[i].hash) begin
              bad++; $display("FAIL rand_event it=%0d dut=%0d got=k%0d@%0d n=%h want=k%0d@%0d n=%h", it, d,
                              act[i].kind, act[i].cyc - c0, act[i].nonce, exp_q[i].kind, exp_q[i].cyc - c0,
                              exp_q[i].nonce);
            end
          end
        end
        total++;
        if (((d == 0) ? hd_a : hd_b) !== CW'(exp_hd)) begin
          bad++; $display("FAIL rand_hashes it=%0d dut=%0d got=%0d want=%0d", it, d, (d == 0) ? hd_a : hd_b, exp_hd);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; pow_store = 1'b0; pow_hash = 256'd0;
    job_blob = 576'd0; job_target = 64'd0; job_start = 64'd0; job_count = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_sweep();
    test_hit();
    test_wrap();
    test_zero();
    test_abort();
    test_reset_midjob();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
